// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and trigger-level helpers for the UART receive path
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_HI = 2'b11
  } trig_level_e;

  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_TOUT_CYCLES = 704;

  // Map the two-bit trigger code onto an entry count; HI keeps two slots of headroom.
  function automatic int trig_threshold(input logic [1:0] lvl, input int depth);
    case (trig_level_e'(lvl))
      TRIG_1:  return 1;
      TRIG_4:  return 4;
      TRIG_8:  return 8;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - receive FIFO storage, one write port and one asynchronous read port
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [8:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [8:0]    rdata
);

  logic [8:0] mem [DEPTH];

  // Contents are deliberately not reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO with trigger-level and character-timeout interrupts
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int AW          = 4,
  parameter int TOUT_CYCLES = DEFAULT_TOUT_CYCLES
) (
  input  logic          bclk,
  input  logic          rstn,
  input  logic          rx_done,
  input  logic [7:0]    rx_dout,
  input  logic          rx_error,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          ovr_clr,
  input  logic [1:0]    trig_level,
  output logic [7:0]    rd_data,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          trig_irq,
  output logic          tout_irq
);

  localparam int            TW       = $clog2(TOUT_CYCLES);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TOUT_CYCLES - 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic [AW:0]   thr;
  logic [TW-1:0] tcnt;
  logic          push_ok;
  logic          pop_ok;
  logic          drop;
  logic [8:0]    head;

  // Decide which of push/pop actually take effect this cycle; flush overrides both.
  always_comb begin
    pop_ok     = rd_en & ~empty & ~flush;
    push_ok    = rx_done & (~full | rd_en) & ~flush;
    drop       = rx_done & full & ~rd_en;
    count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    if (flush) count_next = '0;
    thr        = (AW+1)'(trig_threshold(trig_level, DEPTH));
  end

  // Pointers, occupancy and the status flags derived from the next occupancy.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      trig_irq <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == (AW+1)'(DEPTH));
      trig_irq <= (count_next >= thr);
    end
  end

  // Sticky overrun: a dropped push beats a same-cycle clear, and flush leaves it alone.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn)        overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  // Idle counter runs only while data sits unread; it saturates one short of the limit.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn)                                   tcnt <= '0;
    else if (flush | push_ok | pop_ok | empty)   tcnt <= '0;
    else if (tcnt != TOUT_MAX)                   tcnt <= tcnt + TW'(1);
  end

  // Timeout interrupt holds until the FIFO sees any accepted activity.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn)                          tout_irq <= 1'b0;
    else if (flush | push_ok | pop_ok)  tout_irq <= 1'b0;
    else if (tcnt == TOUT_MAX)          tout_irq <= 1'b1;
  end

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (bclk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata ({rx_error, rx_dout}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign rd_data = empty ? 8'h00 : head[7:0];
  assign rd_err  = ~empty & head[8];

endmodule
